// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, derived totals and signal widths
// for the VGA timing generator.
package vga_timing_pkg;

  localparam int CLK_DIV   = 4;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 29;

  localparam int H_TOTAL    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL    = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_SYNC_BEG = H_VISIBLE + H_FRONT;
  localparam int H_SYNC_END = H_SYNC_BEG + H_SYNC - 1;
  localparam int V_SYNC_BEG = V_VISIBLE + V_FRONT;
  localparam int V_SYNC_END = V_SYNC_BEG + V_SYNC - 1;

  localparam int COLOUR_W = 12;
  localparam int CNT_W    = 10;
  localparam int X_W      = 10;
  localparam int Y_W      = 9;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-side bundle between the timing generator, the colour selector
// and the VGA connector.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  // No valid/ready: the generator owns the pixel cadence. X/Y change one CLK
  // after pix_en and hold for a pixel period; COLOUR_IN must be settled by the
  // next pix_en and is sampled only on that edge.
  logic [COLOUR_W-1:0] COLOUR_IN;
  logic [X_W-1:0]      X;
  logic [Y_W-1:0]      Y;
  logic                HS;
  logic                VS;
  logic [COLOUR_W-1:0] COLOUR_OUT;
  logic                FRAME_TICK;

  modport master (
    input  COLOUR_IN,
    output X, Y, HS, VS, COLOUR_OUT, FRAME_TICK
  );

  modport slave (
    output COLOUR_IN,
    input  X, Y, HS, VS, COLOUR_OUT, FRAME_TICK
  );

endinterface

// File: rtl/wrap_counter.sv
// Enabled modulo counter: counts 0..MAX_VAL, wraps to 0, and flags the
// enabled cycle in which it wraps.
module wrap_counter #(
  parameter int WIDTH   = 10,
  parameter int MAX_VAL = 799
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    wrap    = en && (count_q == MAX_V);
    if (en) begin
      count_d = (count_q == MAX_V) ? '0 : count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel divider, H/V counters, registered X/Y,
// blanked colour pipeline with aligned syncs, and a once-per-frame tick.
module vga_timing_gen #(
  parameter int CLK_DIV   = vga_timing_pkg::CLK_DIV,
  parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
  parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int H_BACK    = vga_timing_pkg::H_BACK,
  parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
  parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
  input  logic              CLK,
  input  logic              RESETN,
  vga_timing_gen_if.master  bus
);
  import vga_timing_pkg::*;

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] V_LAST_C = CNT_W'(V_VISIBLE - 1);
  localparam logic [CNT_W-1:0] HS_LO    = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_HI    = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_LO    = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_HI    = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             pix_en;
  logic [CNT_W-1:0] h_cnt;
  logic             h_wrap;
  logic [CNT_W-1:0] v_cnt;
  logic             v_wrap;
  logic             unused_bits;

  wrap_counter #(.WIDTH(DIV_W), .MAX_VAL(CLK_DIV - 1)) u_div (
    .clk(CLK), .rst_n(RESETN), .en(1'b1), .count(div_cnt), .wrap(pix_en)
  );

  wrap_counter #(.WIDTH(CNT_W), .MAX_VAL(H_TOT - 1)) u_h (
    .clk(CLK), .rst_n(RESETN), .en(pix_en), .count(h_cnt), .wrap(h_wrap)
  );

  // h_wrap already implies pix_en, so V steps exactly once per line end.
  wrap_counter #(.WIDTH(CNT_W), .MAX_VAL(V_TOT - 1)) u_v (
    .clk(CLK), .rst_n(RESETN), .en(h_wrap), .count(v_cnt), .wrap(v_wrap)
  );

  assign unused_bits = ^{div_cnt, v_wrap};

  logic                h_vis;
  logic                v_vis;
  logic                hs_act;
  logic                vs_act;

  logic [X_W-1:0]      x_q, x_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic                vis_q, vis_d;        // visible_d: flag of the X/Y now presented
  logic                hs_pre_q, hs_pre_d;
  logic                vs_pre_q, vs_pre_d;
  logic                hs_q, hs_d;
  logic                vs_q, vs_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;
  logic                tick_q, tick_d;

  assign h_vis  = (h_cnt < H_VIS_C);
  assign v_vis  = (v_cnt < V_VIS_C);
  assign hs_act = (h_cnt >= HS_LO) && (h_cnt <= HS_HI);
  assign vs_act = (v_cnt >= VS_LO) && (v_cnt <= VS_HI);

  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    vis_d    = vis_q;
    hs_pre_d = hs_pre_q;
    vs_pre_d = vs_pre_q;
    hs_d     = hs_q;
    vs_d     = vs_q;
    colour_d = colour_q;
    tick_d   = h_wrap && (v_cnt == V_LAST_C);
    if (pix_en) begin
      x_d      = h_vis ? h_cnt : '0;
      y_d      = v_vis ? v_cnt[Y_W-1:0] : '0;
      vis_d    = h_vis && v_vis;
      hs_pre_d = ~hs_act;
      vs_pre_d = ~vs_act;
      // Syncs take a second stage so they line up with the returned colour.
      hs_d     = hs_pre_q;
      vs_d     = vs_pre_q;
      colour_d = vis_q ? bus.COLOUR_IN : '0;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      x_q      <= '0;
      y_q      <= '0;
      vis_q    <= 1'b0;
      hs_pre_q <= 1'b1;
      vs_pre_q <= 1'b1;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      colour_q <= '0;
      tick_q   <= 1'b0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      vis_q    <= vis_d;
      hs_pre_q <= hs_pre_d;
      vs_pre_q <= vs_pre_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      colour_q <= colour_d;
      tick_q   <= tick_d;
    end
  end

  assign bus.X          = x_q;
  assign bus.Y          = y_q;
  assign bus.HS         = hs_q;
  assign bus.VS         = vs_q;
  assign bus.COLOUR_OUT = colour_q;
  assign bus.FRAME_TICK = tick_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance and a shrunken-timing
// instance, both checked every CLK against a closed-form timing model.
module tb_vga_timing_gen;

  typedef struct packed {
    int hv; int hf; int hs; int hb;
    int vv; int vf; int vs; int vb;
  } tim_t;

  typedef struct packed {
    logic [9:0]  x;
    logic [8:0]  y;
    logic        hs;
    logic        vs;
    logic [11:0] col;
    logic        tick;
  } exp_t;

  localparam tim_t T_DEF = '{640, 16, 96, 48, 480, 10, 2, 29};
  localparam tim_t T_SML = '{16, 2, 4, 3, 6, 2, 2, 3};
  localparam int   DIV   = 4;
  localparam int   SML_FRAME_CLK = 25 * 13 * DIV;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  vga_timing_gen_if bus_d ();
  vga_timing_gen_if bus_s ();

  vga_timing_gen u_dut_d (
    .CLK    (clk),
    .RESETN (rst_n),
    .bus    (bus_d.master)
  );

  vga_timing_gen #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
    .V_VISIBLE(6),  .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) u_dut_s (
    .CLK    (clk),
    .RESETN (rst_n),
    .bus    (bus_s.master)
  );

  int          total = 0;
  int          bad   = 0;
  int          n     = 0;       // rising edges since reset release
  int          cyc   = 0;
  logic [11:0] col_pix = '0;    // COLOUR_IN captured at the latest pixel edge

  int hs_low_d, abc_d, zero_d, max_x_d;
  int vs_low_s, tick_s, max_x_s, max_y_s;
  int last_tick_cyc = -1;
  int tick_gap      = -1;

  // Everything follows from the pixel count p = n / DIV: X/Y show pixel p-1,
  // colour and syncs show pixel p-2.
  function automatic exp_t model(input tim_t t, input int edges, input logic [11:0] c);
    exp_t e;
    int ht, vt, p, q, h, v;
    ht = t.hv + t.hf + t.hs + t.hb;
    vt = t.vv + t.vf + t.vs + t.vb;
    p  = edges / DIV;
    e  = '{x: '0, y: '0, hs: 1'b1, vs: 1'b1, col: '0, tick: 1'b0};
    if (p >= 1) begin
      q = p - 1;
      h = q % ht;
      v = (q / ht) % vt;
      e.x = (h < t.hv) ? 10'(h) : 10'd0;
      e.y = (v < t.vv) ? 9'(v) : 9'd0;
    end
    if (p >= 2) begin
      q = p - 2;
      h = q % ht;
      v = (q / ht) % vt;
      e.hs  = !((h >= t.hv + t.hf) && (h < t.hv + t.hf + t.hs));
      e.vs  = !((v >= t.vv + t.vf) && (v < t.vv + t.vf + t.vs));
      e.col = ((h < t.hv) && (v < t.vv)) ? c : 12'h000;
    end
    if ((edges > 0) && (edges % DIV == 0) && ((p % (ht * vt)) == ht * t.vv)) begin
      e.tick = 1'b1;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s n=%0d observed=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask

  task automatic check_all();
    exp_t e;
    e = model(T_DEF, n, col_pix);
    chk("d_x",    32'(bus_d.X),          32'(e.x));
    chk("d_y",    32'(bus_d.Y),          32'(e.y));
    chk("d_hs",   32'(bus_d.HS),         32'(e.hs));
    chk("d_vs",   32'(bus_d.VS),         32'(e.vs));
    chk("d_col",  32'(bus_d.COLOUR_OUT), 32'(e.col));
    chk("d_tick", 32'(bus_d.FRAME_TICK), 32'(e.tick));
    e = model(T_SML, n, col_pix);
    chk("s_x",    32'(bus_s.X),          32'(e.x));
    chk("s_y",    32'(bus_s.Y),          32'(e.y));
    chk("s_hs",   32'(bus_s.HS),         32'(e.hs));
    chk("s_vs",   32'(bus_s.VS),         32'(e.vs));
    chk("s_col",  32'(bus_s.COLOUR_OUT), 32'(e.col));
    chk("s_tick", 32'(bus_s.FRAME_TICK), 32'(e.tick));
  endtask

  task automatic clear_stats();
    hs_low_d = 0; abc_d = 0; zero_d = 0; max_x_d = 0;
    vs_low_s = 0; tick_s = 0; max_x_s = 0; max_y_s = 0;
  endtask

  task automatic collect();
    if (bus_d.HS === 1'b0) hs_low_d++;
    if (bus_d.COLOUR_OUT === 12'hABC) abc_d++;
    if (bus_d.COLOUR_OUT === 12'h000) zero_d++;
    if (int'(bus_d.X) > max_x_d) max_x_d = int'(bus_d.X);
    if (bus_s.VS === 1'b0) vs_low_s++;
    if (int'(bus_s.X) > max_x_s) max_x_s = int'(bus_s.X);
    if (int'(bus_s.Y) > max_y_s) max_y_s = int'(bus_s.Y);
    if (bus_s.FRAME_TICK === 1'b1) begin
      tick_s++;
      if (last_tick_cyc >= 0) tick_gap = cyc - last_tick_cyc;
      last_tick_cyc = cyc;
    end
  endtask

  task automatic step(input logic [11:0] c);
    bus_d.COLOUR_IN = c;
    bus_s.COLOUR_IN = c;
    @(posedge clk);
    cyc++;
    if (rst_n) begin
      n++;
      if (n % DIV == 0) col_pix = c;
    end
    #1;
    check_all();
    collect();
  endtask

  initial begin
    logic found;
    rst_n = 1'b0;
    bus_d.COLOUR_IN = '0;
    bus_s.COLOUR_IN = '0;
    clear_stats();

    // Reset state while held
    for (int i = 0; i < 3; i++) step(12'($urandom));

    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(12'($urandom));
    chk("first_pix_x",   32'(bus_d.X),          32'd0);
    chk("first_pix_hs",  32'(bus_d.HS),         32'd1);
    chk("first_pix_vs",  32'(bus_d.VS),         32'd1);
    chk("first_pix_col", 32'(bus_d.COLOUR_OUT), 32'h000);
    for (int i = 0; i < 4; i++) step(12'($urandom));
    chk("second_pix_x_d", 32'(bus_d.X), 32'd1);
    chk("second_pix_x_s", 32'(bus_s.X), 32'd1);

    // Colour toggling every CLK: only the pixel-edge value may pass
    for (int i = 0; i < 200; i++) step((i % 2 == 0) ? 12'hF00 : 12'h00F);

    // Held colour across one full-size line
    for (int i = 0; i < 16; i++) step(12'hABC);
    clear_stats();
    for (int i = 0; i < 800 * DIV; i++) step(12'hABC);
    chk("line_abc_clk",  abc_d,    640 * DIV);
    chk("line_zero_clk", zero_d,   160 * DIV);
    chk("line_hs_low",   hs_low_d, 96 * DIV);
    chk("line_max_x",    max_x_d,  639);

    // One shrunken frame with random colour
    clear_stats();
    for (int i = 0; i < SML_FRAME_CLK; i++) step(12'($urandom));
    chk("frame_vs_low",   vs_low_s, 2 * 25 * DIV);
    chk("frame_ticks",    tick_s,   1);
    chk("frame_tick_gap", tick_gap, SML_FRAME_CLK);
    chk("frame_max_x",    max_x_s,  15);
    chk("frame_max_y",    max_y_s,  5);

    // Mid-frame reset at H=12, V=5 of the shrunken instance
    found = 1'b0;
    for (int i = 0; i < 2 * SML_FRAME_CLK && !found; i++) begin
      step(12'($urandom));
      if (((n / DIV) % 325 == 5 * 25 + 12) && (n % DIV == 2)) found = 1'b1;
    end
    chk("reset_point_reached", 32'(found), 32'd1);
    chk("pre_reset_y_s", 32'(bus_s.Y), 32'd5);
    rst_n = 1'b0;
    #1;
    n = 0;
    check_all();
    for (int i = 0; i < 3; i++) step(12'($urandom));

    rst_n = 1'b1;
    clear_stats();
    last_tick_cyc = -1;
    for (int i = 0; i < 150 * DIV - 1; i++) step(12'($urandom));
    chk("no_early_tick", tick_s, 0);
    step(12'($urandom));
    chk("restart_tick", 32'(bus_s.FRAME_TICK), 32'd1);
    for (int i = 0; i < SML_FRAME_CLK; i++) step(12'($urandom));
    chk("restart_ticks", tick_s, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

- Generates 640x480@60 Hz VGA timing from the 100 MHz system clock.
- Drives the pixel coordinates X/Y that the play-state colour selector consumes.
- Takes back that block's registered 12-bit colour, blanks it outside the visible area, and outputs it aligned with HS/VS to the VGA connector.
- Also produces a once-per-frame tick that the snake movement logic uses.

## Interface
Parameters:
- CLK_DIV, 4: system clocks per pixel (25 MHz pixel rate).
- H_VISIBLE, 640 / H_FRONT, 16 / H_SYNC, 96 / H_BACK, 48: horizontal timing, total 800 pixels.
- V_VISIBLE, 480 / V_FRONT, 10 / V_SYNC, 2 / V_BACK, 29: vertical timing, total 521 lines.

Ports:
- CLK  in  1  system clock, 100 MHz; all logic on rising edge.
- RESETN  in  1  reset, asynchronous, active-low.
- COLOUR_IN  in  12  colour from the colour selector, {R[3:0],G[3:0],B[3:0]}.
- X  out  10  horizontal pixel coordinate; 0 outside visible columns.
- Y  out  9  vertical line coordinate; 0 outside visible lines.
- HS  out  1  horizontal sync, active-low.
- VS  out  1  vertical sync, active-low.
- COLOUR_OUT  out  12  colour to the DAC; 12'h000 while blanked.
- FRAME_TICK  out  1  one-CLK pulse per frame.

## Operation
- Divider counts 0..CLK_DIV-1 and wraps. pix_en is asserted in the cycle where divider == CLK_DIV-1.
- H counter:
  - 10 bits, range 0..799.
  - Increments on pix_en and wraps 799 -> 0.
- V counter:
  - 10 bits internally, range 0..520.
  - Increments on pix_en when H == 799; wraps 520 -> 0.
- Visible area: H < 640 and V < 480.
- X, Y:
  - Registered from the counters on pix_en.
  - X = H[9:0] when H < 640, else 0.
  - Y = V[8:0] when V < 480, else 0.
  - Y never exceeds 479.
- Pipeline stage 1 (on pix_en):
  - COLOUR_OUT <= visible_d ? COLOUR_IN : 12'h000.
  - visible_d is the visible flag of the coordinates that X/Y presented at the previous pix_en.
- Sync outputs:
  - HS low when H in 656..751.
  - VS low when V in 490..491.
  - Both are delayed through one pix_en stage so they stay aligned with COLOUR_OUT.
- FRAME_TICK: high for exactly one CLK in the cycle after pix_en when V transitions 479 -> 480.

Reset values (asynchronous, on RESETN low):
- Divider = 0, H = 0, V = 0.
- X = 0, Y = 0.
- HS = 1, VS = 1.
- COLOUR_OUT = 12'h000, FRAME_TICK = 0, visible_d = 0.

## Timing
- Coordinate latency: X/Y change one CLK after pix_en and are then stable for CLK_DIV cycles. The colour selector registers its output within one CLK, leaving 3 CLK of margin.
- Colour latency:
  - COLOUR_OUT shows a given X/Y pixel one pixel period (CLK_DIV CLKs) after X/Y present it.
  - HS/VS carry the same delay.
- Wrap-around:
  - At H == 799 with V == 520, both counters wrap together on the same pix_en.
  - No frame shortening or duplicate line is permitted.
- Reset mid-frame:
  - All state returns to reset values immediately.
  - After RESETN deassertion the first pix_en occurs on the 4th rising CLK edge.
  - The frame restarts at (0,0) with no FRAME_TICK until V reaches 480.
- COLOUR_IN changes between pix_en edges have no effect on COLOUR_OUT.
- Frame period: 800 × 521 × 4 = 1,667,200 CLK.

## Structure
- Package vga_timing_pkg holds:
  - the eight H/V timing constants and CLK_DIV;
  - the derived H_TOTAL, V_TOTAL, sync start/end values;
  - the colour width constant (12).
- One sub-module, wrap_counter, is parameterised by width and max value, with enable input and wrap output. It is instantiated three times: divider, H, V.
- The sync/visible/pipeline logic stays in the top module.

## Test plan
- Reset release, then 4 CLK: pix_en fires; X goes 0 -> 1 on the following pixel; HS = VS = 1; COLOUR_OUT = 000.
- COLOUR_IN held at 12'hABC for a full line: COLOUR_OUT = ABC for exactly 640 pixel periods and 000 for 160; HS is low for exactly 96 × 4 = 384 CLK per line.
- Full frame: VS is low for exactly 2 × 800 × 4 = 6400 CLK. FRAME_TICK pulses once per 1,667,200 CLK, one CLK wide.
- Y observed over a frame: maximum 479, 0 in lines 480..520. X maximum 639.
- RESETN pulsed low at H = 300, V = 200: all outputs go to reset values in the same cycle, and counting restarts from (0,0).
- COLOUR_IN toggled every CLK between F00 and 00F: COLOUR_OUT takes only the value present at each pix_en edge and is stable for 4 CLK.
